// File: rtl/cache_prof_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_prof_pkg
// Description : Shared types and helpers for the set-associative cache
//               profiler: FSM state encoding, replacement-mode encodings and
//               a saturating increment used by the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_prof_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic REPL_LRU  = 1'b0;
    localparam logic REPL_FIFO = 1'b1;

    // Counters up to 32 bits wide are handled; callers zero-extend into the
    // 32-bit argument and truncate the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage : cache_prof_pkg
`default_nettype wire

// File: rtl/cache_set_repl.sv
`default_nettype none
// ============================================================================
// Module      : cache_set_repl
// Description : Combinational hit detection, victim selection and age /
//               FIFO-pointer update for one cache set.
// Ports       : i_valid/i_tags/i_ages/i_ptr - current state of the set
//               i_tag, i_mode                - lookup tag, 0=LRU 1=FIFO
//               o_hit, o_way                 - hit flag, hit or victim way
//               o_evict                      - miss displaces a valid line
//               o_new_ages, o_new_ptr        - set state after this access
// Revision    : 1.0 - initial release
// ============================================================================
module cache_set_repl
    import cache_prof_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int TAG_W = 22,
    parameter int AGE_W = 2
) (
    input  logic [WAYS-1:0]            i_valid,
    input  logic [WAYS-1:0][TAG_W-1:0] i_tags,
    input  logic [WAYS-1:0][AGE_W-1:0] i_ages,
    input  logic [AGE_W-1:0]           i_ptr,
    input  logic [TAG_W-1:0]           i_tag,
    input  logic                       i_mode,
    output logic                       o_hit,
    output logic [AGE_W-1:0]           o_way,
    output logic                       o_evict,
    output logic [WAYS-1:0][AGE_W-1:0] o_new_ages,
    output logic [AGE_W-1:0]           o_new_ptr
);

    logic [WAYS-1:0]  w_hit_vec;
    logic [AGE_W-1:0] w_hit_way;
    logic [AGE_W-1:0] w_inv_way;
    logic             w_any_inv;
    logic [AGE_W-1:0] w_lru_way;
    logic [AGE_W-1:0] w_victim;
    logic [AGE_W-1:0] w_ref_age;
    logic             w_touch_ages;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_cmp
            assign w_hit_vec[g] = i_valid[g] && (i_tags[g] == i_tag);
        end
    endgenerate

    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        w_any_inv = 1'b0;
        w_lru_way = '0;
        // Descending scan so the lowest matching index wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = AGE_W'(w);
            if (!i_valid[w]) begin
                w_inv_way = AGE_W'(w);
                w_any_inv = 1'b1;
            end
            if (i_ages[w] == AGE_W'(WAYS - 1)) w_lru_way = AGE_W'(w);
        end

        o_hit = |w_hit_vec;

        if (i_mode == REPL_FIFO) w_victim = i_ptr;
        else if (w_any_inv)      w_victim = w_inv_way;
        else                     w_victim = w_lru_way;

        o_way   = o_hit ? w_hit_way : w_victim;
        o_evict = !o_hit && i_valid[w_victim];

        // An invalid victim behaves as the oldest entry.
        if (o_hit)                  w_ref_age = i_ages[w_hit_way];
        else if (i_valid[w_victim]) w_ref_age = i_ages[w_victim];
        else                        w_ref_age = AGE_W'(WAYS - 1);

        // FIFO hits leave the set untouched; everything else ages the set.
        w_touch_ages = !(o_hit && (i_mode == REPL_FIFO));

        o_new_ages = i_ages;
        if (w_touch_ages) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == o_way)        o_new_ages[w] = '0;
                else if (i_ages[w] < w_ref_age) o_new_ages[w] = i_ages[w] + AGE_W'(1);
            end
        end

        o_new_ptr = i_ptr;
        if ((i_mode == REPL_FIFO) && !o_hit) o_new_ptr = i_ptr + AGE_W'(1);
    end

endmodule : cache_set_repl
`default_nettype wire

// File: rtl/cache_set_assoc_profiler.sv
`default_nettype none
// ============================================================================
// Module      : cache_set_assoc_profiler
// Description : Set-associative cache model that consumes an address trace
//               and keeps saturating access/hit/miss/eviction statistics.
//               One access takes three cycles: accept, lookup, update.
// Ports       : clk, reset (async, active low)
//               trace_ready, mem_addr, repl_mode -> trace input
//               trace_accept                     -> high when idle
//               clear_stats, flush               -> sync counter / line clear
//               updated                          -> pulse after each update
//               access/hit/miss/evict_count      -> statistics
// Revision    : 1.0 - initial release
// ============================================================================
module cache_set_assoc_profiler
    import cache_prof_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int CNT_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              trace_accept,
    input  logic              repl_mode,
    input  logic              clear_stats,
    input  logic              flush,
    output logic              updated,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  evict_count
);

    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int AGE_W    = $clog2(WAYS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;

    logic [TAG_W-1:0]   r_tag_q;
    logic [INDEX_W-1:0] r_index_q;
    logic               r_mode_q;

    logic [SETS-1:0][WAYS-1:0]            r_valid;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] r_tags;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] r_ages;
    logic [SETS-1:0][AGE_W-1:0]           r_ptr;

    logic                       w_hit;
    logic [AGE_W-1:0]           w_way;
    logic                       w_evict;
    logic [WAYS-1:0][AGE_W-1:0] w_new_ages;
    logic [AGE_W-1:0]           w_new_ptr;

    logic                       r_hit;
    logic [AGE_W-1:0]           r_way;
    logic                       r_evict;
    logic [WAYS-1:0][AGE_W-1:0] r_new_ages;
    logic [AGE_W-1:0]           r_new_ptr;

    logic r_updated;

    // Line-offset bits do not influence the cache model.
    logic w_unused_offset;
    assign w_unused_offset = ^mem_addr[OFFSET_W-1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        trace_accept = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                trace_accept = 1'b1;
                w_accept     = trace_ready;
                if (trace_ready) w_state_next = LOOKUP;
            end
            LOOKUP:  w_state_next = UPDATE;
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ request latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_q   <= '0;
            r_index_q <= '0;
            r_mode_q  <= REPL_LRU;
        end else if (w_accept) begin
            r_tag_q   <= mem_addr[OFFSET_W+INDEX_W +: TAG_W];
            r_index_q <= mem_addr[OFFSET_W +: INDEX_W];
            r_mode_q  <= repl_mode;
        end
    end

    // -------------------------------------------------------------- lookup
    cache_set_repl #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .AGE_W (AGE_W)
    ) u_repl (
        .i_valid    (r_valid[r_index_q]),
        .i_tags     (r_tags[r_index_q]),
        .i_ages     (r_ages[r_index_q]),
        .i_ptr      (r_ptr[r_index_q]),
        .i_tag      (r_tag_q),
        .i_mode     (r_mode_q),
        .o_hit      (w_hit),
        .o_way      (w_way),
        .o_evict    (w_evict),
        .o_new_ages (w_new_ages),
        .o_new_ptr  (w_new_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit      <= 1'b0;
            r_way      <= '0;
            r_evict    <= 1'b0;
            r_new_ages <= '0;
            r_new_ptr  <= '0;
        end else if (r_state == LOOKUP) begin
            r_hit      <= w_hit;
            r_way      <= w_way;
            r_evict    <= w_evict;
            r_new_ages <= w_new_ages;
            r_new_ptr  <= w_new_ptr;
        end
    end

    // ------------------------------------------------------- set storage
    // Flush outranks the fill; a lookup already latched still completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_ages  <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ages  <= '0;
            r_ptr   <= '0;
        end else if (r_state == UPDATE) begin
            r_ages[r_index_q] <= r_new_ages;
            r_ptr[r_index_q]  <= r_new_ptr;
            if (!r_hit) r_valid[r_index_q][r_way] <= 1'b1;
        end
    end

    // Tags are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if ((r_state == UPDATE) && !r_hit && !flush)
            r_tags[r_index_q][r_way] <= r_tag_q;
    end

    // ----------------------------------------------------------- counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            evict_count  <= '0;
        end else if (clear_stats) begin
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            evict_count  <= '0;
        end else if (r_state == UPDATE) begin
            access_count <= CNT_W'(sat_inc(32'(access_count), CNT_MAX));
            if (r_hit) hit_count <= CNT_W'(sat_inc(32'(hit_count), CNT_MAX));
            else       miss_count <= CNT_W'(sat_inc(32'(miss_count), CNT_MAX));
            if (r_evict) evict_count <= CNT_W'(sat_inc(32'(evict_count), CNT_MAX));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_updated <= 1'b0;
        else        r_updated <= (r_state == UPDATE);
    end

    assign updated = r_updated;

endmodule : cache_set_assoc_profiler
`default_nettype wire

// File: tb/tb_cache_set_assoc_profiler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_set_assoc_profiler
// Description : Directed scoreboard bench for cache_set_assoc_profiler with a
//               4-bit counter configuration so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_set_assoc_profiler;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             trace_ready = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic             trace_accept;
    logic             repl_mode = 1'b0;
    logic             clear_stats = 1'b0;
    logic             flush = 1'b0;
    logic             updated;
    logic [CNT_W-1:0] access_count, hit_count, miss_count, evict_count;

    cache_set_assoc_profiler #(
        .ADDR_W(32), .LINE_BYTES(16), .SETS(64), .WAYS(4), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trace_ready  (trace_ready),
        .mem_addr     (mem_addr),
        .trace_accept (trace_accept),
        .repl_mode    (repl_mode),
        .clear_stats  (clear_stats),
        .flush        (flush),
        .updated      (updated),
        .access_count (access_count),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .evict_count  (evict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int hit;
        int miss;
        int evict;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc = 0, m_hit = 0, m_miss = 0, m_evict = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_zero();
        m_acc = 0; m_hit = 0; m_miss = 0; m_evict = 0;
    endtask

    // Monitor: every updated pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (updated) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_updated actual=1 required=0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_access", int'(access_count), e.acc);
                check("sb_hit",    int'(hit_count),    e.hit);
                check("sb_miss",   int'(miss_count),   e.miss);
                check("sb_evict",  int'(evict_count),  e.evict);
            end
        end
    end

    task automatic wait_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!trace_accept && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = trace_accept;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
    endtask

    // One access; collide raises clear_stats and flush on the update edge.
    task automatic issue(input logic [31:0] addr, input logic mode,
                         input bit exp_hit, input bit exp_evict, input bit collide);
        bit   ok;
        exp_t e;
        wait_idle(ok);
        if (!ok) return;
        trace_ready = 1'b1;
        mem_addr    = addr;
        repl_mode   = mode;
        @(posedge clk);
        @(negedge clk);
        trace_ready = 1'b0;
        mem_addr    = 32'hDEAD_BEEF;
        check("accept_low_lookup", int'(trace_accept), 0);
        if (collide) begin
            model_zero();
        end else begin
            m_acc = sat(m_acc);
            if (exp_hit) m_hit = sat(m_hit);
            else         m_miss = sat(m_miss);
            if (exp_evict) m_evict = sat(m_evict);
        end
        e.acc = m_acc; e.hit = m_hit; e.miss = m_miss; e.evict = m_evict;
        sb_q.push_back(e);
        @(negedge clk);
        check("accept_low_update", int'(trace_accept), 0);
        if (collide) begin
            clear_stats = 1'b1;
            flush       = 1'b1;
        end
        @(negedge clk);
        clear_stats = 1'b0;
        flush       = 1'b0;
        check("updated_latency", int'(updated), 1);
    endtask

    task automatic clean();
        bit ok;
        wait_idle(ok);
        clear_stats = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        flush       = 1'b0;
        model_zero();
    endtask

    task automatic check_totals(input string tag, input int a, input int h,
                                input int m, input int v);
        @(negedge clk);
        check({tag, "_access"}, int'(access_count), a);
        check({tag, "_hit"},    int'(hit_count),    h);
        check({tag, "_miss"},   int'(miss_count),   m);
        check({tag, "_evict"},  int'(evict_count),  v);
    endtask

    logic [31:0] seq_addr [8] = '{32'h000, 32'h400, 32'h800, 32'hC00,
                                  32'h000, 32'h1000, 32'h000, 32'h400};
    bit lru_hit   [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    bit lru_evict [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    bit ff_hit    [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    bit ff_evict  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_access",  int'(access_count), 0);
        check("rst_hit",     int'(hit_count),    0);
        check("rst_miss",    int'(miss_count),   0);
        check("rst_evict",   int'(evict_count),  0);
        check("rst_updated", int'(updated),      0);
        check("rst_accept",  int'(trace_accept), 1);

        // Cold then warm
        issue(32'h1000, 1'b0, 0, 0, 0);
        issue(32'h1000, 1'b0, 1, 0, 0);
        check_totals("cw", 2, 1, 1, 0);

        // LRU eviction
        clean();
        for (int i = 0; i < 8; i++) issue(seq_addr[i], 1'b0, lru_hit[i], lru_evict[i], 0);
        check_totals("lru", 8, 2, 6, 2);

        // FIFO eviction
        clean();
        for (int i = 0; i < 8; i++) issue(seq_addr[i], 1'b1, ff_hit[i], ff_evict[i], 0);
        check_totals("fifo", 8, 1, 7, 3);

        // Saturation
        clean();
        for (int i = 0; i < 20; i++) issue(32'h40, 1'b0, (i != 0), 0, 0);
        check_totals("sat", 15, 15, 1, 0);

        // clear_stats + flush on the update edge of a miss
        clean();
        issue(32'h480, 1'b0, 0, 0, 0);
        issue(32'h080, 1'b0, 0, 0, 1);
        check_totals("coll", 0, 0, 0, 0);
        issue(32'h080, 1'b0, 0, 0, 0);
        check_totals("coll_after", 1, 0, 1, 0);

        // Reset asserted while an access is in LOOKUP
        begin
            bit ok;
            wait_idle(ok);
            trace_ready = 1'b1;
            mem_addr    = 32'h0;
            repl_mode   = 1'b0;
            @(posedge clk);
            @(negedge clk);
            trace_ready = 1'b0;
            reset       = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("rst_mid_no_updated", int'(updated), 0);
            end
            check("rst_mid_access", int'(access_count), 0);
            check("rst_mid_miss",   int'(miss_count),   0);
            check("rst_mid_accept", int'(trace_accept), 1);
            model_zero();
            issue(32'h0, 1'b0, 0, 0, 0);
            check_totals("rst_after", 1, 0, 1, 0);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cache_set_assoc_profiler
`default_nettype wire
